// File: rtl/cae_window_feeder_pkg.sv
// ----------------------------------------------------------------------------
// cae_window_feeder_pkg
// Shared definitions for the CAE row-interface transmit side.
//   - Default geometry (pixel width, kernel size, image size).
//   - Feeder FSM state encoding.
//   - Line-buffer select encoding (top / middle / bottom row buffer).
//   - Default-width packed window-row type for consumers of the row ports.
// ----------------------------------------------------------------------------
package cae_window_feeder_pkg;

    localparam int CAE_DATA_WIDTH = 16;
    localparam int CAE_KSIZE      = 3;
    localparam int CAE_IMG_W      = 28;
    localparam int CAE_IMG_H      = 28;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } feeder_state_t;

    typedef enum logic [1:0] {
        BUF_TOP = 2'd0,
        BUF_MID = 2'd1,
        BUF_BOT = 2'd2
    } buf_sel_t;

    // One window row; element 0 (leftmost pixel) sits in the low bits.
    typedef logic [CAE_KSIZE-1:0][CAE_DATA_WIDTH-1:0] win_row_t;

endpackage

// File: rtl/cae_line_buffer.sv
// ----------------------------------------------------------------------------
// cae_line_buffer
// Three image-row buffers (B0 top, B1 middle, B2 bottom) with:
//   - one pixel write port (wr_en, wr_sel, wr_col, wr_data),
//   - a shift-up operation (B0 <= B1, B1 <= B2) used when the window moves
//     down one image row,
//   - a KSIZE-wide combinational column read starting at rd_col, one output
//     per buffer (rd_row1 from B0, rd_row2 from B1, rd_row3 from B2).
// ----------------------------------------------------------------------------
module cae_line_buffer
    import cae_window_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = CAE_DATA_WIDTH,
    parameter int KSIZE      = CAE_KSIZE,
    parameter int IMG_W      = CAE_IMG_W
)(
    input  logic                                clk_i,
    input  logic                                wr_en,
    input  buf_sel_t                            wr_sel,
    input  logic [$clog2(IMG_W)-1:0]            wr_col,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                shift_en,
    input  logic [$clog2(IMG_W)-1:0]            rd_col,
    output logic [KSIZE-1:0][DATA_WIDTH-1:0]    rd_row1,
    output logic [KSIZE-1:0][DATA_WIDTH-1:0]    rd_row2,
    output logic [KSIZE-1:0][DATA_WIDTH-1:0]    rd_row3
);

    localparam int COL_W = $clog2(IMG_W);

    logic [DATA_WIDTH-1:0] buf_b0 [IMG_W];
    logic [DATA_WIDTH-1:0] buf_b1 [IMG_W];
    logic [DATA_WIDTH-1:0] buf_b2 [IMG_W];

    // NOTE: the row buffers have no reset; every location is rewritten before
    // it is read, and leaving them unreset lets them map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (shift_en) begin
            buf_b0 <= buf_b1;
            buf_b1 <= buf_b2;
        end else if (wr_en) begin
            case (wr_sel)
                BUF_TOP: buf_b0[wr_col] <= wr_data;
                BUF_MID: buf_b1[wr_col] <= wr_data;
                default: buf_b2[wr_col] <= wr_data;
            endcase
        end
    end

    // NOTE: every element of every output is assigned on each pass, so no
    // latch can be inferred.
    always_comb begin
        for (int k = 0; k < KSIZE; k++) begin
            rd_row1[k] = buf_b0[rd_col + COL_W'(k)];
            rd_row2[k] = buf_b1[rd_col + COL_W'(k)];
            rd_row3[k] = buf_b2[rd_col + COL_W'(k)];
        end
    end

endmodule

// File: rtl/cae_window_feeder.sv
// ----------------------------------------------------------------------------
// cae_window_feeder
// Transmit side of the CAE row interface. Buffers KSIZE rows of a raster
// pixel stream and presents successive KSIZE x KSIZE windows to the engine.
//   clk_i, rst          : clock, synchronous active-high reset
//   start               : begin a frame (honoured only when idle)
//   pix_in/valid/ready  : pixel stream handshake
//   data_row1..3_out    : window rows, element 0 in the low bits
//   conv_enable         : one-cycle pulse, new window presented
//   conv_comp           : engine finished the current window
//   win_col, win_row    : position of the window's top-left pixel
//   busy, frame_done    : frame in progress / last window completed pulse
// The row outputs are registered while in ISSUE, so conv_enable and the new
// window become visible together in the first WAIT cycle; conv_comp seen in
// that same cycle belongs to no window yet and is ignored.
// ----------------------------------------------------------------------------
module cae_window_feeder
    import cae_window_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = CAE_DATA_WIDTH,
    parameter int KSIZE      = CAE_KSIZE,
    parameter int IMG_W      = CAE_IMG_W,
    parameter int IMG_H      = CAE_IMG_H
)(
    input  logic                          clk_i,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         pix_in,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic [KSIZE*DATA_WIDTH-1:0]   data_row1_out,
    output logic [KSIZE*DATA_WIDTH-1:0]   data_row2_out,
    output logic [KSIZE*DATA_WIDTH-1:0]   data_row3_out,
    output logic                          conv_enable,
    input  logic                          conv_comp,
    output logic [$clog2(IMG_W)-1:0]      win_col,
    output logic [$clog2(IMG_H)-1:0]      win_row,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] PCOL_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] WCOL_LAST = COL_W'(IMG_W - KSIZE);
    localparam logic [ROW_W-1:0] WROW_LAST = ROW_W'(IMG_H - KSIZE);

    feeder_state_t    state;
    buf_sel_t         wr_sel;
    logic [COL_W-1:0] pcol;
    logic [COL_W-1:0] wcol;
    logic [ROW_W-1:0] wrow;

    logic                             wr_en;
    logic                             shift_en;
    logic [KSIZE-1:0][DATA_WIDTH-1:0] rd_row1;
    logic [KSIZE-1:0][DATA_WIDTH-1:0] rd_row2;
    logic [KSIZE-1:0][DATA_WIDTH-1:0] rd_row3;

    // pix_ready is only ever high in FILL, so the handshake alone qualifies
    // a write.
    assign wr_en    = pix_valid && pix_ready;
    assign shift_en = (state == S_SHIFT);

    cae_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .KSIZE      (KSIZE),
        .IMG_W      (IMG_W)
    ) u_line_buffer (
        .clk_i    (clk_i),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_col   (pcol),
        .wr_data  (pix_in),
        .shift_en (shift_en),
        .rd_col   (wcol),
        .rd_row1  (rd_row1),
        .rd_row2  (rd_row2),
        .rd_row3  (rd_row3)
    );

    // NOTE: all state and outputs here are updated with non-blocking
    // assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state         <= S_IDLE;
            wr_sel        <= BUF_TOP;
            pcol          <= '0;
            wcol          <= '0;
            wrow          <= '0;
            pix_ready     <= 1'b0;
            data_row1_out <= '0;
            data_row2_out <= '0;
            data_row3_out <= '0;
            conv_enable   <= 1'b0;
            win_col       <= '0;
            win_row       <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            conv_enable <= 1'b0;
            frame_done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FILL;
                        wr_sel    <= BUF_TOP;
                        pcol      <= '0;
                        wcol      <= '0;
                        wrow      <= '0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                S_FILL: begin
                    if (pix_valid && pix_ready) begin
                        if (pcol == PCOL_LAST) begin
                            pcol <= '0;
                            // Filling always finishes in the bottom buffer:
                            // three rows from B0 at frame start, one row
                            // into B2 after a shift.
                            if (wr_sel == BUF_BOT) begin
                                state     <= S_ISSUE;
                                pix_ready <= 1'b0;
                            end else begin
                                wr_sel <= (wr_sel == BUF_TOP) ? BUF_MID : BUF_BOT;
                            end
                        end else begin
                            pcol <= pcol + COL_W'(1);
                        end
                    end
                end

                S_ISSUE: begin
                    data_row1_out <= rd_row1;
                    data_row2_out <= rd_row2;
                    data_row3_out <= rd_row3;
                    win_col       <= wcol;
                    win_row       <= wrow;
                    conv_enable   <= 1'b1;
                    state         <= S_WAIT;
                end

                S_WAIT: begin
                    if (conv_comp && !conv_enable) begin
                        if (wcol < WCOL_LAST) begin
                            wcol  <= wcol + COL_W'(1);
                            state <= S_ISSUE;
                        end else if (wrow < WROW_LAST) begin
                            wcol  <= '0;
                            wrow  <= wrow + ROW_W'(1);
                            state <= S_SHIFT;
                        end else begin
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end

                S_SHIFT: begin
                    wr_sel    <= BUF_BOT;
                    pix_ready <= 1'b1;
                    state     <= S_FILL;
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cae_window_feeder.sv
// ----------------------------------------------------------------------------
// tb_cae_window_feeder
// Drives whole frames through cae_window_feeder (IMG_W=5, IMG_H=4, KSIZE=3)
// with an engine model that answers conv_enable with conv_comp after a set
// delay. Expected windows come from the image array sliced directly.
// ----------------------------------------------------------------------------
module tb_cae_window_feeder;

    localparam int DW   = 16;
    localparam int K    = 3;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int WPR  = W - K + 1;
    localparam int NWIN = WPR * (H - K + 1);
    localparam int CW   = $clog2(W);
    localparam int RW   = $clog2(H);

    logic              clk_i = 1'b0;
    logic              rst;
    logic              start;
    logic [DW-1:0]     pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic [K*DW-1:0]   data_row1_out;
    logic [K*DW-1:0]   data_row2_out;
    logic [K*DW-1:0]   data_row3_out;
    logic              conv_enable;
    logic              conv_comp;
    logic [CW-1:0]     win_col;
    logic [RW-1:0]     win_row;
    logic              busy;
    logic              frame_done;

    always #5 clk_i = ~clk_i;

    cae_window_feeder #(
        .DATA_WIDTH (DW),
        .KSIZE      (K),
        .IMG_W      (W),
        .IMG_H      (H)
    ) dut (
        .clk_i         (clk_i),
        .rst           (rst),
        .start         (start),
        .pix_in        (pix_in),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .data_row1_out (data_row1_out),
        .data_row2_out (data_row2_out),
        .data_row3_out (data_row3_out),
        .conv_enable   (conv_enable),
        .conv_comp     (conv_comp),
        .win_col       (win_col),
        .win_row       (win_row),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    typedef struct {
        int              row;
        int              col;
        logic [K*DW-1:0] r1;
        logic [K*DW-1:0] r2;
        logic [K*DW-1:0] r3;
    } win_obs_t;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] img [H][W];
    win_obs_t      obs_q[$];

    int n_accept;
    int n_done_pulse;
    int ready_viol;
    int hold_viol;
    int ce_lat_viol;
    int done_viol;
    bit timed_out;

    // Reference model: window i slices the image directly.
    function automatic win_obs_t exp_win(int i);
        win_obs_t e;
        e.row = i / WPR;
        e.col = i % WPR;
        for (int k = 0; k < K; k++) begin
            e.r1[k*DW +: DW] = img[e.row][e.col + k];
            e.r2[k*DW +: DW] = img[e.row + 1][e.col + k];
            e.r3[k*DW +: DW] = img[e.row + 2][e.col + k];
        end
        return e;
    endfunction

    task automatic fill_image(input bit rnd);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = rnd ? DW'($urandom) : DW'(10 * r + c);
    endtask

    // Runs one frame cycle by cycle: raster source, engine model and
    // observers. abort_win > 0 asserts rst once that many windows were seen.
    task automatic run_frame(input int valid_pct, input int comp_delay,
                             input bit spurious, input int abort_win,
                             input bit poke_start);
        int idx = 0, cnt = 0, completed = 0, cyc = 0, needed;
        int last_acc = -10, comp_cyc = -10, done_cyc = -1;
        bit outstanding = 0, acc, comp_now, ce_s;
        logic [K*DW-1:0] h1, h2, h3;
        logic [CW-1:0] hc;
        logic [RW-1:0] hr;

        obs_q.delete();
        n_done_pulse = 0; ready_viol = 0; hold_viol = 0;
        ce_lat_viol = 0; done_viol = 0; timed_out = 0;

        if (spurious) begin
            conv_comp = 1'b1;
            repeat (3) @(posedge clk_i);
            #1;
            conv_comp = 1'b0;
        end
        start = 1'b1;
        @(posedge clk_i);
        #1;
        start = 1'b0;

        while (1) begin
            if (frame_done) begin
                n_done_pulse++;
                if (cyc != comp_cyc || completed != NWIN || !busy) done_viol++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                if (busy) done_viol++;
                break;
            end
            if (conv_enable) begin
                obs_q.push_back('{int'(win_row), int'(win_col),
                                  data_row1_out, data_row2_out, data_row3_out});
                if (outstanding) hold_viol++;
                outstanding = 1;
                cnt = comp_delay;
                h1 = data_row1_out; h2 = data_row2_out; h3 = data_row3_out;
                hc = win_col; hr = win_row;
                if ((obs_q.size() - 1) % WPR == 0 && cyc != last_acc + 1)
                    ce_lat_viol++;
                if (abort_win > 0 && obs_q.size() == abort_win) begin
                    rst = 1'b1;
                    pix_valid = 1'b0;
                    conv_comp = 1'b0;
                    break;
                end
            end else if (outstanding) begin
                if (data_row1_out !== h1 || data_row2_out !== h2 ||
                    data_row3_out !== h3 || win_col !== hc || win_row !== hr)
                    hold_viol++;
            end
            needed = (completed / WPR + K) * W;
            if (pix_ready && (outstanding || idx >= needed)) ready_viol++;

            comp_now = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) comp_now = 1;
            end
            if (spurious && conv_enable) comp_now = 1;
            if (spurious && !outstanding && $urandom_range(0, 3) == 0) comp_now = 1;
            conv_comp = comp_now;

            if (idx < W * H && $urandom_range(1, 100) <= valid_pct) begin
                pix_valid = 1'b1;
                pix_in    = img[idx / W][idx % W];
            end else begin
                pix_valid = 1'b0;
                pix_in    = DW'($urandom);
            end
            if (poke_start) start = ($urandom_range(0, 5) == 0);
            acc  = pix_valid && pix_ready;
            ce_s = conv_enable;

            @(posedge clk_i);
            #1;
            cyc++;
            if (acc) begin
                idx++;
                last_acc = cyc;
            end
            if (comp_now && outstanding && !ce_s) begin
                completed++;
                outstanding = 0;
                comp_cyc = cyc;
            end
            if (cyc > 20000) begin
                timed_out = 1;
                break;
            end
        end
        pix_valid = 1'b0;
        conv_comp = 1'b0;
        start     = 1'b0;
        n_accept  = idx;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        total++;
        if ({busy, pix_ready, conv_enable, frame_done} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {busy, pix_ready, conv_enable, frame_done});
        end
        total++;
        if ({data_row1_out, data_row2_out, data_row3_out, win_col, win_row} !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h expected 0",
                     {data_row1_out, data_row2_out, data_row3_out, win_col, win_row});
        end
        rst = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_basic_frame();
        win_obs_t e;
        fill_image(1'b0);
        run_frame(100, 3, 1'b0, 0, 1'b0);
        total++;
        if (timed_out || obs_q.size() != NWIN) begin
            bad++;
            $display("FAIL basic_count: got %0d expected %0d (timeout=%0d)",
                     obs_q.size(), NWIN, timed_out);
        end
        for (int i = 0; i < obs_q.size() && i < NWIN; i++) begin
            e = exp_win(i);
            total++;
            if (obs_q[i].row != e.row || obs_q[i].col != e.col || obs_q[i].r1 !== e.r1 ||
                obs_q[i].r2 !== e.r2 || obs_q[i].r3 !== e.r3) begin
                bad++;
                $display("FAIL basic_win%0d: got (%0d,%0d) %h/%h/%h expected (%0d,%0d) %h/%h/%h",
                         i, obs_q[i].row, obs_q[i].col, obs_q[i].r1, obs_q[i].r2, obs_q[i].r3,
                         e.row, e.col, e.r1, e.r2, e.r3);
            end
        end
        total++;
        if (obs_q.size() > 0 && obs_q[0].r1 !== {16'd2, 16'd1, 16'd0}) begin
            bad++;
            $display("FAIL basic_first_row1: got %h expected 000200010000", obs_q[0].r1);
        end
        total++;
        if (obs_q.size() == NWIN && obs_q[NWIN-1].r3 !== {16'd34, 16'd33, 16'd32}) begin
            bad++;
            $display("FAIL basic_last_row3: got %h expected 002200210020", obs_q[NWIN-1].r3);
        end
        total++;
        if (n_done_pulse != 1 || done_viol != 0) begin
            bad++;
            $display("FAIL basic_frame_done: got pulses=%0d viol=%0d expected 1/0",
                     n_done_pulse, done_viol);
        end
        total++;
        if (ce_lat_viol != 0 || n_accept != W * H) begin
            bad++;
            $display("FAIL basic_latency_accept: got lat_viol=%0d accepted=%0d expected 0/%0d",
                     ce_lat_viol, n_accept, W * H);
        end
    endtask

    task automatic test_random_valid();
        win_obs_t e;
        for (int rep = 0; rep < 3; rep++) begin
            fill_image(1'b1);
            run_frame(50, $urandom_range(1, 4), 1'b0, 0, 1'b0);
            total++;
            if (timed_out || obs_q.size() != NWIN || n_accept != W * H) begin
                bad++;
                $display("FAIL rand_count: got windows=%0d accepted=%0d expected %0d/%0d",
                         obs_q.size(), n_accept, NWIN, W * H);
            end
            for (int i = 0; i < obs_q.size() && i < NWIN; i++) begin
                e = exp_win(i);
                total++;
                if (obs_q[i].row != e.row || obs_q[i].col != e.col || obs_q[i].r1 !== e.r1 ||
                    obs_q[i].r2 !== e.r2 || obs_q[i].r3 !== e.r3) begin
                    bad++;
                    $display("FAIL rand_win%0d: got (%0d,%0d) %h/%h/%h expected (%0d,%0d) %h/%h/%h",
                             i, obs_q[i].row, obs_q[i].col, obs_q[i].r1, obs_q[i].r2,
                             obs_q[i].r3, e.row, e.col, e.r1, e.r2, e.r3);
                end
            end
            total++;
            if (ready_viol != 0 || n_done_pulse != 1) begin
                bad++;
                $display("FAIL rand_ready: got ready_viol=%0d done_pulses=%0d expected 0/1",
                         ready_viol, n_done_pulse);
            end
        end
    endtask

    task automatic test_spurious_comp();
        win_obs_t e;
        fill_image(1'b1);
        run_frame(70, 3, 1'b1, 0, 1'b0);
        total++;
        if (timed_out || obs_q.size() != NWIN) begin
            bad++;
            $display("FAIL spurious_count: got %0d expected %0d", obs_q.size(), NWIN);
        end
        for (int i = 0; i < obs_q.size() && i < NWIN; i++) begin
            e = exp_win(i);
            total++;
            if (obs_q[i].row != e.row || obs_q[i].col != e.col || obs_q[i].r1 !== e.r1 ||
                obs_q[i].r2 !== e.r2 || obs_q[i].r3 !== e.r3) begin
                bad++;
                $display("FAIL spurious_win%0d: got (%0d,%0d) expected (%0d,%0d)",
                         i, obs_q[i].row, obs_q[i].col, e.row, e.col);
            end
        end
        total++;
        if (n_done_pulse != 1 || done_viol != 0 || ready_viol != 0) begin
            bad++;
            $display("FAIL spurious_done: got pulses=%0d done_viol=%0d ready_viol=%0d expected 1/0/0",
                     n_done_pulse, done_viol, ready_viol);
        end
    endtask

    task automatic test_hold_wait();
        fill_image(1'b1);
        run_frame(100, 50, 1'b0, 0, 1'b0);
        total++;
        if (timed_out || obs_q.size() != NWIN) begin
            bad++;
            $display("FAIL hold_count: got %0d expected %0d", obs_q.size(), NWIN);
        end
        total++;
        if (hold_viol != 0) begin
            bad++;
            $display("FAIL hold_stable: got %0d changed cycles expected 0", hold_viol);
        end
    endtask

    task automatic test_reset_mid_frame();
        win_obs_t e;
        fill_image(1'b1);
        run_frame(100, 3, 1'b0, 2, 1'b0);
        total++;
        if (obs_q.size() != 2 || obs_q[1].row != 0 || obs_q[1].col != 1) begin
            bad++;
            $display("FAIL rstmid_pre: got %0d windows expected 2 ending at (0,1)", obs_q.size());
        end
        @(posedge clk_i);
        #1;
        total++;
        if ({busy, pix_ready, conv_enable, frame_done} !== 4'b0) begin
            bad++;
            $display("FAIL rstmid_flags: got %b expected 0000",
                     {busy, pix_ready, conv_enable, frame_done});
        end
        total++;
        if ({data_row1_out, data_row2_out, data_row3_out, win_col, win_row} !== '0) begin
            bad++;
            $display("FAIL rstmid_data: got %h expected 0",
                     {data_row1_out, data_row2_out, data_row3_out, win_col, win_row});
        end
        rst = 1'b0;
        @(posedge clk_i);
        #1;
        fill_image(1'b1);
        run_frame(80, 2, 1'b0, 0, 1'b0);
        e = exp_win(0);
        total++;
        if (obs_q.size() != NWIN || obs_q[0].row != 0 || obs_q[0].col != 0 ||
            obs_q[0].r1 !== e.r1 || obs_q[0].r2 !== e.r2 || obs_q[0].r3 !== e.r3) begin
            bad++;
            $display("FAIL rstmid_restart: got %0d windows first %h expected %0d first %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].r1 : '0, NWIN, e.r1);
        end
    endtask

    task automatic test_start_while_busy();
        win_obs_t e;
        fill_image(1'b1);
        run_frame(60, 3, 1'b0, 0, 1'b1);
        total++;
        if (timed_out || obs_q.size() != NWIN || n_done_pulse != 1) begin
            bad++;
            $display("FAIL busy_start_count: got windows=%0d pulses=%0d expected %0d/1",
                     obs_q.size(), n_done_pulse, NWIN);
        end
        e = exp_win(NWIN - 1);
        total++;
        if (obs_q.size() == NWIN && (obs_q[NWIN-1].r2 !== e.r2 || obs_q[NWIN-1].col != e.col)) begin
            bad++;
            $display("FAIL busy_start_last: got %h expected %h", obs_q[NWIN-1].r2, e.r2);
        end
        repeat (5) @(posedge clk_i);
        #1;
        total++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_idle: got busy=%b done=%b expected 0/0", busy, frame_done);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        conv_comp = 1'b0;
        test_reset();
        test_basic_frame();
        test_random_valid();
        test_spurious_comp();
        test_hold_wait();
        test_reset_mid_frame();
        test_start_while_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cae_window_feeder.md
Name: cae_window_feeder

Overview:
- Transmit side of the CAE row interface.
- Accepts a raster-order pixel stream, buffers KSIZE image rows, and presents successive KSIZE x KSIZE windows on data_row1/2/3.
- Paces each window with a one-cycle enable pulse and advances only when the engine returns conv_comp.
- Sits between the frame source (DMA/testbench) and CAE_top's data inputs; weights and bias are driven elsewhere.

Parameters:
- DATA_WIDTH, 16, pixel width (matches `DATA_WIDTH).
- KSIZE, 3, window width/height; equals `INPUT_SIZE, fixed at 3 (three row ports).
- IMG_W, 28, pixels per image row; must be >= KSIZE.
- IMG_H, 28, rows per image; must be >= KSIZE.

Ports:
- clk_i  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a frame; accepted only in IDLE
- pix_in  in  DATA_WIDTH  pixel data
- pix_valid  in  1  pixel valid
- pix_ready  out  1  feeder can accept pixel
- data_row1_out  out  KSIZE*DATA_WIDTH  window top row; element 0 (leftmost) in bits [DATA_WIDTH-1:0]
- data_row2_out  out  KSIZE*DATA_WIDTH  window middle row
- data_row3_out  out  KSIZE*DATA_WIDTH  window bottom row
- conv_enable  out  1  one-cycle pulse: new window presented (drives CAE enable)
- conv_comp  in  1  engine finished current window
- win_col  out  $clog2(IMG_W)  column of window's left edge
- win_row  out  $clog2(IMG_H)  row of window's top edge
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last window completes

Behaviour:
- Clock and reset: one clock (clk_i); reset (rst) is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; counters 0. Line-buffer contents are not cleared.
- Storage: three row buffers of IMG_W x DATA_WIDTH (B0 top, B1, B2 bottom), plus pixel column counter pcol and window counters wcol/wrow.
- States: IDLE, FILL, ISSUE, WAIT, SHIFT, DONE.
- IDLE: pix_ready=0. On start go to FILL with fill target = 3 rows, write pointer at B0, wcol=wrow=0.
- FILL: pix_ready=1.
  - Each pix_valid&pix_ready writes pix_in to the current buffer[pcol] and increments pcol.
  - At pcol==IMG_W-1 the row is complete: pcol wraps to 0 and the pointer advances B0->B1->B2.
  - When the target rows are complete, the next cycle is ISSUE. pix_ready drops in the cycle after the accepting edge.
- ISSUE: data_row1/2/3_out registered from B0/B1/B2[wcol .. wcol+KSIZE-1]; win_col=wcol, win_row=wrow; conv_enable=1 for exactly this cycle; go to WAIT.
  - Latency: last pixel of a row accepted at edge N -> conv_enable high in cycle N+1, data valid the same cycle.
- WAIT: data rows and win_* held stable. On conv_comp:
  - if wcol < IMG_W-KSIZE: wcol++, go to ISSUE;
  - else if wrow < IMG_H-KSIZE: wcol=0, wrow++, go to SHIFT;
  - else go to DONE.
- SHIFT (1 cycle): B0<=B1, B1<=B2; go to FILL with target = 1 row into B2.
- DONE: frame_done=1 for one cycle, go to IDLE; busy=0 from the next cycle.
- Windows per frame: (IMG_W-KSIZE+1)*(IMG_H-KSIZE+1).
- pix_ready is 0 outside FILL; pixels offered then are not consumed.
- conv_comp outside WAIT is ignored. conv_comp in the same cycle as conv_enable (ISSUE) is ignored; at most one window completes per WAIT.
- start while busy is ignored.
- rst mid-frame: next cycle in IDLE with all outputs 0. A partially received frame is discarded; the source must restart from pixel 0.

Decomposition:
- Shared package (parameters.v / cae_pkg): DATA_WIDTH, KSIZE (= INPUT_SIZE), IMG_W, IMG_H defaults; state enum type; window-row packed type logic [KSIZE-1:0][DATA_WIDTH-1:0].
- One sub-module: cae_line_buffer (three row buffers, write port, shift-up operation, KSIZE-wide column read mux).
- FSM and counters stay in cae_window_feeder.

Test Plan (IMG_W=5, IMG_H=4, KSIZE=3, pixel value = 10*row+col, engine model returns conv_comp 3 cycles after conv_enable):
- Full frame -> exactly 6 conv_enable pulses in order (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). First window rows = {0,1,2},{10,11,12},{20,21,22}. Window (1,2) rows = {12,13,14},{22,23,24},{32,33,34}. frame_done pulses once, 1 cycle after the 6th conv_comp.
- pix_valid toggled 50% randomly -> same 6 windows and values; pix_ready=0 throughout ISSUE/WAIT/SHIFT; no pixel lost or duplicated (20 handshakes total).
- Spurious conv_comp in IDLE, in FILL, and coincident with conv_enable -> no window advance; windows still counted 6.
- Hold conv_comp low for 50 cycles in WAIT -> data_row*_out, win_col, win_row unchanged; conv_enable not re-pulsed.
- rst asserted after window (0,1) issued -> next cycle busy=0, all outputs 0. New start plus a fresh frame -> first window is (0,0) with correct values.
- start pulsed while busy -> ignored; frame completes normally with a single frame_done.
